// File: rtl/data_sram_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_pkg
// Shared definitions for the data SRAM bank:
//   - DATA_W_DEF / ADDR_W_DEF : default data width and word-address width
//   - bank_state_e            : bank FSM encoding (ST_CLEAR, ST_IDLE)
// -----------------------------------------------------------------------------
package data_sram_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef enum logic {
    ST_CLEAR = 1'b0,  // zeroing memory after reset, one word per cycle
    ST_IDLE  = 1'b1   // serving requests
  } bank_state_e;

endpackage

// File: rtl/data_sram_array.sv
// -----------------------------------------------------------------------------
// data_sram_array
// Storage array: one write port with per-byte-lane enables, one asynchronous
// read port, no reset (contents are whatever was last written).
// Ports:
//   clk_i    : clock, writes land on the rising edge
//   we_i     : write strobe
//   wen_i    : per-byte-lane enable, bit i covers wdata_i[8i+7:8i]
//   waddr_i  : write word address
//   wdata_i  : write data
//   raddr_i  : read word address
//   rdata_o  : read data, combinational from raddr_i
// -----------------------------------------------------------------------------
module data_sram_array
  import data_sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DATA_W/8-1:0]   wen_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < LANES; i++) begin
        if (wen_i[i]) begin
          mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_sram_bank.sv
// -----------------------------------------------------------------------------
// data_sram_bank
// Single-ported SRAM bank with byte-lane writes, 1-cycle registered reads and
// an optional post-reset zeroing pass.
//
// Configuration macro: DATA_SRAM_CLEAR_EN
//   defined   : after reset the bank walks addresses 0..2**ADDR_W-1 writing
//               zero (ST_CLEAR), ready stays low until the walk completes.
//   undefined : reset goes straight to ST_IDLE; memory is undefined until
//               written.
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   req          : access request
//   we           : 1 = write, 0 = read
//   wen          : per-byte-lane write enable
//   addr         : word address
//   wdata        : write data
//   ready        : bank can accept a request this cycle
//   rvalid       : rdata carries a read result this cycle
//   rdata        : registered read data, held while rvalid is 0
//   dbg_state_o  : current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where req && ready. A
// request presented while ready is 0 is dropped, not queued. ready is 0 in
// every cycle rst_n is 0. An accepted read produces rvalid=1 for exactly one
// cycle, in the cycle following acceptance; if rst_n is low in that cycle the
// result is discarded (rvalid stays 0).
// -----------------------------------------------------------------------------
module data_sram_bank
  import data_sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   wen,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  ready,
  output logic                  rvalid,
  output logic [DATA_W-1:0]     rdata,
  output bank_state_e           dbg_state_o
);

  localparam int LANES = DATA_W / 8;

  bank_state_e         state_q, state_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                accept;
  logic                rd_accept;
  logic                wr_accept;

  logic                mem_we;
  logic [LANES-1:0]    mem_wen;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  // Gated by rst_n so ready drops in the very cycle reset is asserted.
  assign ready     = rst_n && (state_q == ST_IDLE);
  assign accept    = req && ready;
  assign rd_accept = accept && !we;
  assign wr_accept = accept && we;

`ifdef DATA_SRAM_CLEAR_EN
  localparam bank_state_e RST_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CLR_LAST) begin
        state_d = ST_IDLE;
      end
    end
  end

  // The clear pass owns the write port while in ST_CLEAR; no request can be
  // accepted then, so there is no contention with wr_accept.
  always_comb begin
    mem_we    = wr_accept;
    mem_wen   = wen;
    mem_waddr = addr;
    mem_wdata = wdata;
    if (rst_n && (state_q == ST_CLEAR)) begin
      mem_we    = 1'b1;
      mem_wen   = '1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
    end
  end
`else
  localparam bank_state_e RST_STATE = ST_IDLE;

  assign state_d   = ST_IDLE;
  assign mem_we    = wr_accept;
  assign mem_wen   = wen;
  assign mem_waddr = addr;
  assign mem_wdata = wdata;
`endif

  always_comb begin
    rvalid_d = rd_accept;
    rdata_d  = rdata_q;
    if (rd_accept) begin
      rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
`ifdef DATA_SRAM_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
`ifdef DATA_SRAM_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  // A read accepted just before reset must not surface while rst_n is low.
  assign rvalid      = rvalid_q && rst_n;
  assign rdata       = rdata_q;
  assign dbg_state_o = state_q;

  data_sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .wen_i   (mem_wen),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr_i (addr),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_data_sram_bank.sv
// -----------------------------------------------------------------------------
// tb_data_sram_bank
// Directed bench for data_sram_bank with ADDR_W=4, DATA_W=32. A behavioural
// model (byte-addressable word array plus a count of clear cycles remaining)
// predicts ready/rvalid/rdata every cycle; a queue of hand-computed read
// results pins the model. Builds with or without DATA_SRAM_CLEAR_EN.
// -----------------------------------------------------------------------------
module tb_data_sram_bank;
  import data_sram_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BOUND  = 4 * DEPTH + 8;
`ifdef DATA_SRAM_CLEAR_EN
  localparam int EXP_LAT = DEPTH;
`else
  localparam int EXP_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [3:0]        wen = 4'h0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  bank_state_e       dut_state;

  data_sram_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .we          (we),
    .wen         (wen),
    .addr        (addr),
    .wdata       (wdata),
    .ready       (ready),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .dbg_state_o (dut_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_mem   [DEPTH];
  logic [3:0]        m_known [DEPTH] = '{default: 4'h0};
  logic              m_started = 1'b0;
  int                m_clr_left = 0;
  logic              m_rvalid = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  logic              m_rknown = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_started = 1'b1;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rknown  = 1'b1;
`ifdef DATA_SRAM_CLEAR_EN
      // No access can land before the zeroing pass ends, so the whole array
      // is simply zero from the model's point of view.
      m_clr_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]   = '0;
        m_known[i] = 4'hF;
      end
`else
      m_clr_left = 0;
`endif
    end else if (m_started) begin
      m_rvalid = 1'b0;
      if (m_clr_left > 0) begin
        m_clr_left--;
      end else if (req) begin
        if (we) begin
          for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
              m_mem[addr][8*i +: 8] = wdata[8*i +: 8];
              m_known[addr][i]      = 1'b1;
            end
          end
        end else begin
          m_rvalid = 1'b1;
          m_rdata  = m_mem[addr];
          m_rknown = &m_known[addr];
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_rvalid;
    if (m_started) begin
      exp_ready  = rst_n && (m_clr_left == 0);
      exp_rvalid = m_rvalid && rst_n;
      chk("ready", 32'(ready), 32'(exp_ready));
      chk("rvalid", 32'(rvalid), 32'(exp_rvalid));
      if (rst_n) chk("fsm_state_idle", 32'(dut_state == ST_IDLE), 32'(exp_ready));
      if (m_rknown) chk("rdata_model", rdata, m_rdata);
      if (rvalid === 1'b1) begin
        if (exp_q.size() == 0) chk("rvalid_spurious", 32'(rvalid), 32'd0);
        else chk("rdata_literal", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic op(input logic w, input logic [3:0] be, input logic [ADDR_W-1:0] a,
                    input logic [DATA_W-1:0] d);
    req = 1'b1; we = w; wen = be; addr = a; wdata = d;
    @(posedge clk); #2;
    req = 1'b0; we = 1'b0; wen = 4'h0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] be);
    op(1'b1, be, a, d);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
    op(1'b0, 4'h0, a, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Counts cycles with ready=0 after reset release; returns at a negedge
  // where ready=1 (or when the bound expires).
  task automatic wait_ready(input int exp_cycles);
    int cnt = 0;
    while (cnt <= BOUND) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      cnt++;
    end
    chk("ready_latency", 32'(cnt), 32'(exp_cycles));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, with a write held on the bus while ready=0; it must be dropped.
    do_reset(2);
    req = 1'b1; we = 1'b1; wen = 4'hF; addr = 4'd2; wdata = 32'hFFFF_FFFF;
    wait_ready(EXP_LAT);
    req = 1'b0; we = 1'b0; wen = 4'h0;
`ifdef DATA_SRAM_CLEAR_EN
    rd(4'd5, 32'h0000_0000);
    rd(4'd2, 32'h0000_0000);
    idle(2);
`endif

    // Byte-lane merge.
    wr(4'd3, 32'hDEAD_BEEF, 4'hF);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    rd(4'd3, 32'hDE22_BE44);
    idle(1);

    // Read immediately after write to the same address.
    wr(4'd7, 32'hCAFE_F00D, 4'hF);
    rd(4'd7, 32'hCAFE_F00D);
    idle(2);

    // Back-to-back reads.
    wr(4'd1, 32'h0000_000A, 4'hF);
    wr(4'd2, 32'h0000_000B, 4'hF);
    wr(4'd3, 32'h0000_000C, 4'hF);
    rd(4'd1, 32'h0000_000A);
    rd(4'd2, 32'h0000_000B);
    rd(4'd3, 32'h0000_000C);
    idle(1);

    // Write with no lanes enabled is accepted but changes nothing.
    wr(4'd3, 32'hFFFF_FFFF, 4'h0);
    rd(4'd3, 32'h0000_000C);
    wr(4'd12, 32'h7777_7777, 4'hF);
    wr(4'd15, 32'h0102_0304, 4'b1000);
    wr(4'd15, 32'hA0B0_C0D0, 4'b0111);
    rd(4'd15, 32'h01B0_C0D0);
    idle(2);

    // Reset pulsed mid-clear (after 8 clear cycles).
    do_reset(1);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_ready(EXP_LAT);
`ifdef DATA_SRAM_CLEAR_EN
    rd(4'd12, 32'h0000_0000);
    rd(4'd3, 32'h0000_0000);
`else
    rd(4'd12, 32'h7777_7777);
    rd(4'd3, 32'h0000_000C);
`endif
    idle(1);

    // Reset in the cycle after a read is accepted: no rvalid for that read.
    wr(4'd7, 32'h5A5A_A5A5, 4'hF);
    req = 1'b1; we = 1'b0; wen = 4'h0; addr = 4'd7;
    @(posedge clk); #2;
    req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    wait_ready(EXP_LAT);
`ifdef DATA_SRAM_CLEAR_EN
    rd(4'd7, 32'h0000_0000);
`else
    rd(4'd7, 32'h5A5A_A5A5);
`endif
    idle(3);

    // ---------------- report ----------------
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
